// File: rtl/i2s_tx.sv
// I2S (Philips format) bus-master transmitter: FIFO-buffered stereo frames serialised MSB-first on DOUT.
// Define I2S_TX_MONO_EN to transmit the left sample in both slots and store only DATA_W bits per entry.
module i2s_tx #(
    parameter int DATA_W     = 32,
    parameter int CLK_DIV    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              BCLK,
    output logic              WS,
    output logic              DOUT,
    output logic              frame_start,
    output logic              underrun
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = $clog2(2 * DATA_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SR_W   = 2 * DATA_W;
`ifdef I2S_TX_MONO_EN
    localparam int ENTRY_W = DATA_W;
`else
    localparam int ENTRY_W = 2 * DATA_W;
`endif

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * DATA_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_WS   = SLOT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]   div_cnt;
    logic [SLOT_W-1:0]  slot;
    logic [SLOT_W-1:0]  slot_nxt;
    logic [SR_W-1:0]    shreg;
    logic [SR_W-1:0]    load_word;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic empty, full, push, pop;
    logic tick, fall, frame_edge, stop, load;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = load && !empty;
    assign head    = mem[rd_ptr];

`ifdef I2S_TX_MONO_EN
    logic unused_right;
    assign unused_right = ^s_right;
    assign wr_entry     = s_left;
    assign load_word    = empty ? '0 : {head, head};
`else
    assign wr_entry  = {s_left, s_right};
    assign load_word = empty ? '0 : head;
`endif

    // NOTE: the storage array has no reset; the reset of count and pointers alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timing strobes: a fall is the cycle whose edge drives BCLK 1->0
    // ------------------------------------------------------------------
    assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);
    assign fall       = tick && BCLK;
    assign frame_edge = fall && (slot == '0);
    assign stop       = frame_edge && (state == DRAIN) && !en;
    assign load       = frame_edge && !stop;
    assign slot_nxt   = (slot == SLOT_LAST) ? '0 : slot + 1'b1;

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit clock, word select and serialiser
    // ------------------------------------------------------------------
    assign DOUT = shreg[SR_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            BCLK        <= 1'b0;
            WS          <= 1'b0;
            slot        <= '0;
            shreg       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= pop;
            underrun    <= load && empty;
            // Stopping lands exactly on a fall, so BCLK is already heading low.
            if (state == IDLE || stop) begin
                div_cnt <= '0;
                BCLK    <= 1'b0;
                WS      <= 1'b0;
                slot    <= '0;
                shreg   <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    BCLK <= !BCLK;
                end
                if (fall) begin
                    slot  <= slot_nxt;
                    WS    <= (slot_nxt >= SLOT_WS);
                    shreg <= load ? load_word : {shreg[SR_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, a BCLK-rise monitor rebuilds words and compares.
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int DATA_W     = 32;
    localparam int CLK_DIV    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int BCLK_CLK   = 6;    // clk cycles per BCLK period
    localparam int FRAME_CLK  = 384;  // 64 BCLK periods per stereo frame

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        en      = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_left  = '0;
    logic [31:0] s_right = '0;
    logic        s_ready, bclk, ws, dout, frame_start, underrun;

    i2s_tx #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .BCLK       (bclk),
        .WS         (ws),
        .DOUT       (dout),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int last_load = 0;

    typedef struct {
        bit          under;
        logic [31:0] l;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    bit   kind_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_underrun();
        exp_t e;
        e.under = 1'b1;
        e.l     = '0;
        e.r     = '0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
        int   waited = 0;
        bit   ok;
        exp_t e;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (!s_ready && waited < 4 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        ok = s_ready;
        check("push_accept", s_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        e.under = 1'b0;
        e.l     = l;
`ifdef I2S_TX_MONO_EN
        e.r     = l;
`else
        e.r     = r;
`endif
        if (ok) exp_q.push_back(e);
    endtask

    task automatic wait_load(output bit was_under);
        int waited;
        @(negedge clk);
        waited = 1;
        while (!(frame_start || underrun) && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        check("load_seen", frame_start || underrun, 1'b1);
        was_under = underrun;
        last_load = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int keep);
        int waited = 0;
        int busy   = 0;
        while (exp_q.size() > keep && waited < 4 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        check("frames_left", exp_q.size(), keep);
        repeat (2 * BCLK_CLK) @(negedge clk);
        for (int i = 0; i < 4 * BCLK_CLK; i++) begin
            if (bclk || ws || dout || frame_start || underrun) busy++;
            @(negedge clk);
        end
        check("idle_quiet", busy, 0);
        check("loads_left", kind_q.size(), 0);
    endtask

    task automatic frame_done(input logic [31:0] l, input logic [31:0] r);
        exp_t e;
        bit   k;
        check("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("left_word", l, e.l);
            check("right_word", r, e.r);
            if (kind_q.size() > 0) k = kind_q.pop_front();
            else k = ~e.under;
            check("load_kind", k, e.under);
        end
    endtask

    // Monitor: sample at negedge, shift DOUT in on BCLK rises, a WS change closes the previous word.
    logic        bclk_q = 1'b0;
    logic        ws_q   = 1'b0;
    logic [31:0] acc    = '0;
    logic [31:0] left_w = '0;
    int          gap    = 1000;
    int          run    = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q = 1'b0;
            ws_q   = 1'b0;
            acc    = '0;
            left_w = '0;
            gap    = 1000;
            run    = 0;
            kind_q.delete();
        end else begin
            if (frame_start) kind_q.push_back(1'b0);
            if (underrun) kind_q.push_back(1'b1);
            if (gap < 1000) gap++;
            if (bclk && !bclk_q) begin
                acc = {acc[30:0], dout};
                if (gap > BCLK_CLK) begin
                    run  = 1;
                    ws_q = ws;
                end else begin
                    check("bclk_period", gap, BCLK_CLK);
                    if (ws != ws_q) begin
                        check("ws_run", run, DATA_W);
                        if (!ws_q) left_w = acc;
                        else frame_done(left_w, acc);
                        run  = 1;
                        ws_q = ws;
                    end else begin
                        run++;
                    end
                end
                gap = 0;
            end
            bclk_q = bclk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit u;
        int c0, t0, cnt;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bclk", bclk, 1'b0);
        check("rst_ws", ws, 1'b0);
        check("rst_dout", dout, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, bit-exact serialisation
        push_frame(32'hA5A5_0001, 32'h8000_00FF);
        en  = 1'b1;
        c0  = cyc;
        cnt = 0;
        while (!bclk && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("first_rise_cycles", cnt, 4);
        check("first_slot0_dout", dout, 1'b0);
        wait_load(u);
        check("first_load_cycles", last_load - c0, 7);
        check("first_load_kind", u, 1'b0);
        en = 1'b0;
        wait_idle(0);

        // FIFO fill, rejected fifth push, ordered output
        push_frame(32'h1111_1111, 32'h2222_2222);
        push_frame(32'h3333_3333, 32'h4444_4444);
        push_frame(32'h5555_5555, 32'h6666_6666);
        push_frame(32'h7777_7777, 32'h8888_8888);
        check("full_s_ready", s_ready, 1'b0);
        s_valid = 1'b1;
        s_left  = 32'hDEAD_BEEF;
        s_right = 32'hFEED_FACE;
        repeat (5) @(negedge clk);
        check("full_reject", s_ready, 1'b0);
        s_valid = 1'b0;
        expect_underrun();
        en = 1'b1;
        wait_load(u);
        check("fill_first_kind", u, 1'b0);
        check("ready_after_pop", s_ready, 1'b1);
        t0 = last_load;
        wait_load(u);
        check("frame_period", last_load - t0, FRAME_CLK);
        wait_load(u);
        wait_load(u);
        wait_load(u);
        check("fill_fifth_underrun", u, 1'b1);
        en = 1'b0;
        wait_idle(0);

        // Underrun on empty FIFO, then recovery
        expect_underrun();
        expect_underrun();
        en = 1'b1;
        wait_load(u);
        check("underrun_first", u, 1'b1);
        t0 = last_load;
        wait_load(u);
        check("underrun_period", last_load - t0, FRAME_CLK);
        push_frame(32'h0F0F_1234, 32'hF0F0_5678);
        wait_load(u);
        check("underrun_recover", u, 1'b0);
        en = 1'b0;
        wait_idle(0);

        // Drain at s=10 of frame 2; frame 3 stays queued across IDLE
        push_frame(32'hCAFE_0001, 32'hBEEF_0002);
        push_frame(32'hCAFE_0003, 32'hBEEF_0004);
        push_frame(32'hCAFE_0005, 32'hBEEF_0006);
        en = 1'b1;
        wait_load(u);
        wait_load(u);
        repeat (54) @(negedge clk);
        en = 1'b0;
        wait_idle(1);
        en = 1'b1;
        wait_load(u);
        check("persist_after_idle", u, 1'b0);
        en = 1'b0;
        wait_idle(0);

        // Push in the load cycle: empty FIFO, then three queued
        expect_underrun();
        expect_underrun();
        en = 1'b1;
        wait_load(u);
        check("sim_first_underrun", u, 1'b1);
        wait_cyc(last_load + FRAME_CLK - 1);
        push_frame(32'h1357_9BDF, 32'h2468_ACE0);
        check("sim_empty_push_underrun", underrun, 1'b1);
        wait_load(u);
        check("sim_frame_next", u, 1'b0);
        t0 = last_load;
        push_frame(32'hA000_0001, 32'hB000_0001);
        push_frame(32'hA000_0002, 32'hB000_0002);
        push_frame(32'hA000_0003, 32'hB000_0003);
        wait_cyc(t0 + FRAME_CLK - 1);
        push_frame(32'hA000_0004, 32'hB000_0004);
        check("sim_pop_with_push", frame_start, 1'b1);
        check("sim_count3_ready", s_ready, 1'b1);
        push_frame(32'hA000_0005, 32'hB000_0005);
        check("sim_count_full", s_ready, 1'b0);
        wait_load(u);
        wait_load(u);
        wait_load(u);
        wait_load(u);
        check("sim_last_kind", u, 1'b0);
        en = 1'b0;
        wait_idle(0);

        // Asynchronous reset mid-frame flushes the FIFO
        push_frame(32'h600D_0001, 32'h600D_0002);
        push_frame(32'h600D_0003, 32'h600D_0004);
        en = 1'b1;
        wait_load(u);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("rst_mid_bclk", bclk, 1'b0);
        check("rst_mid_ws", ws, 1'b0);
        check("rst_mid_dout", dout, 1'b0);
        check("rst_mid_s_ready", s_ready, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_underrun();
        en = 1'b1;
        wait_load(u);
        check("flush_underrun", u, 1'b1);
        en = 1'b0;
        wait_idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
